// File: rtl/hls_axi_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hls_axi_run_ctrl
//  Purpose  : Run controller and AXI outstanding-burst limiter for one HLS
//             core with an AXI4 master port. Turns a valid/ready start
//             command into the ap_start/ap_ready/ap_done handshake. Caps
//             in-flight read and write bursts, and drains them before
//             reporting completion. Reports sticky response-error and
//             timeout status, plus the run length in cycles.
//  Ports    : ap_clk, ap_rst_n            clock, async active-low reset
//             cmd_valid/cmd_ready         start command
//             done_valid/done_ready       completion report
//             done_status[2:0]            {timeout, wr resp err, rd resp err}
//             done_cycles[CYC_W-1:0]      cycles from START entry to DONE entry
//             core_ap_*                   HLS block-level handshake
//             core_arvalid/core_arready   core AR handshake (gated)
//             m_axi_arvalid/m_axi_arready bus AR handshake (gated)
//             core_awvalid/core_awready   core AW handshake (gated)
//             m_axi_awvalid/m_axi_awready bus AW handshake (gated)
//             m_axi_r*, m_axi_b*          monitored response channels
//  Revision : 1.0  initial release
// ============================================================================
module hls_axi_run_ctrl #(
    parameter int MAX_RD_OUT = 4,
    parameter int MAX_WR_OUT = 4,
    parameter int CYC_W      = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [2:0]       done_status,
    output logic [CYC_W-1:0] done_cycles,
    output logic             core_ap_start,
    input  logic             core_ap_ready,
    input  logic             core_ap_done,
    input  logic             core_arvalid,
    output logic             core_arready,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic             core_awvalid,
    output logic             core_awready,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    input  logic             m_axi_rvalid,
    input  logic             m_axi_rready,
    input  logic             m_axi_rlast,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_bvalid,
    input  logic             m_axi_bready,
    input  logic [1:0]       m_axi_bresp
);

    localparam int RD_W = $clog2(MAX_RD_OUT + 1);
    localparam int WR_W = $clog2(MAX_WR_OUT + 1);
    localparam logic [RD_W-1:0]  RD_MAX = RD_W'(MAX_RD_OUT);
    localparam logic [WR_W-1:0]  WR_MAX = WR_W'(MAX_WR_OUT);
    // Timeout fires during the cycle whose count increment reaches TIMEOUT.
    localparam logic [CYC_W-1:0] TO_M1  = CYC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [RD_W-1:0]    rd_out_q, rd_out_d;
    logic [WR_W-1:0]    wr_out_q, wr_out_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]   done_cycles_q, done_cycles_d;
    logic [1:0]         err_q, err_d;
    logic [2:0]         done_status_q, done_status_d;

    logic               rd_room, wr_room;
    logic               ar_hs, aw_hs, r_last_hs, b_hs;
    logic [1:0]         new_err;
    logic               cmd_accept;
    logic               active;
    logic               to_hit;
    logic               enter_done;
    logic [CYC_W-1:0]   cnt_inc;

    // ---------------- address-channel gating (all states) ----------------
    assign rd_room       = (rd_out_q < RD_MAX);
    assign wr_room       = (wr_out_q < WR_MAX);
    assign m_axi_arvalid = core_arvalid  & rd_room;
    assign core_arready  = m_axi_arready & rd_room;
    assign m_axi_awvalid = core_awvalid  & wr_room;
    assign core_awready  = m_axi_awready & wr_room;

    assign ar_hs     = core_arvalid & m_axi_arready & rd_room;
    assign aw_hs     = core_awvalid & m_axi_awready & wr_room;
    assign r_last_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign b_hs      = m_axi_bvalid & m_axi_bready;

    // Error on any R beat, not just the last one.
    assign new_err[0] = m_axi_rvalid & m_axi_rready & (m_axi_rresp != 2'b00);
    assign new_err[1] = b_hs & (m_axi_bresp != 2'b00);

    // ---------------- outstanding counters ----------------
    always_comb begin
        rd_out_d = rd_out_q;
        if (ar_hs && !r_last_hs) begin
            rd_out_d = rd_out_q + RD_W'(1);
        end else if (!ar_hs && r_last_hs && (rd_out_q != '0)) begin
            rd_out_d = rd_out_q - RD_W'(1);
        end
    end

    always_comb begin
        wr_out_d = wr_out_q;
        if (aw_hs && !b_hs) begin
            wr_out_d = wr_out_q + WR_W'(1);
        end else if (!aw_hs && b_hs && (wr_out_q != '0)) begin
            wr_out_d = wr_out_q - WR_W'(1);
        end
    end

    // ---------------- status and run FSM ----------------
    assign cmd_ready  = (state_q == S_IDLE);
    assign cmd_accept = cmd_ready & cmd_valid;
    assign active     = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign to_hit     = (TIMEOUT != 0) && active && (cnt_q == TO_M1);
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CYC_W'(1);

    // A response error arriving on the accept cycle belongs to the new run.
    assign err_d = cmd_accept ? new_err : (err_q | new_err);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_cycles_d = done_cycles_q;
        done_status_d = done_status_q;
        core_ap_start = 1'b0;
        done_valid    = 1'b0;
        enter_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_inc;
                if (to_hit) begin
                    enter_done = 1'b1;
                end else begin
                    core_ap_start = 1'b1;
                    if (core_ap_ready) begin
                        state_d = core_ap_done ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (to_hit) begin
                    enter_done = 1'b1;
                end else if (core_ap_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (to_hit || ((rd_out_q == '0) && (wr_out_q == '0))) begin
                    enter_done = 1'b1;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Snapshot is taken with this cycle's count and errors included.
        if (enter_done) begin
            state_d       = S_DONE;
            done_cycles_d = cnt_inc;
            done_status_d = {to_hit, err_d};
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            rd_out_q      <= '0;
            wr_out_q      <= '0;
            cnt_q         <= '0;
            done_cycles_q <= '0;
            err_q         <= '0;
            done_status_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_out_q      <= rd_out_d;
            wr_out_q      <= wr_out_d;
            cnt_q         <= cnt_d;
            done_cycles_q <= done_cycles_d;
            err_q         <= err_d;
            done_status_q <= done_status_d;
        end
    end

    assign done_status = done_status_q;
    assign done_cycles = done_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_axi_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hls_axi_run_ctrl
//  Purpose  : Self-checking bench for hls_axi_run_ctrl. A run-level model
//             (busy flags, integer burst counts, cycle count) predicts every
//             output each cycle; directed sequences pin literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hls_axi_run_ctrl;

    localparam int MAXR = 2;
    localparam int MAXW = 3;
    localparam int CW   = 32;
    localparam int TO   = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          done_ready = 1'b0;
    logic          core_ap_ready = 1'b0;
    logic          core_ap_done = 1'b0;
    logic          core_arvalid = 1'b0;
    logic          m_axi_arready = 1'b0;
    logic          core_awvalid = 1'b0;
    logic          m_axi_awready = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready = 1'b0;
    logic          m_axi_rlast = 1'b0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;

    logic          cmd_ready, done_valid, core_ap_start;
    logic [2:0]    done_status;
    logic [CW-1:0] done_cycles;
    logic          core_arready, m_axi_arvalid, core_awready, m_axi_awvalid;

    hls_axi_run_ctrl #(
        .MAX_RD_OUT (MAXR),
        .MAX_WR_OUT (MAXW),
        .CYC_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .done_status   (done_status),
        .done_cycles   (done_cycles),
        .core_ap_start (core_ap_start),
        .core_ap_ready (core_ap_ready),
        .core_ap_done  (core_ap_done),
        .core_arvalid  (core_arvalid),
        .core_arready  (core_arready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .core_awvalid  (core_awvalid),
        .core_awready  (core_awready),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (m_axi_bresp)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- run-level reference model ----------------
    int       m_rd = 0, m_wr = 0;          // bursts in flight
    bit       m_er = 1'b0, m_ew = 1'b0;    // sticky response errors
    bit       m_run = 1'b0;                // command accepted, no report yet
    bit       m_ack = 1'b0;                // core acknowledged ap_start
    bit       m_cdone = 1'b0;              // core reported ap_done
    bit       m_dv = 1'b0;                 // report pending
    int       m_cyc = 0;                   // run cycles so far
    logic [2:0] m_stat = 3'b000;
    int       m_dcyc = 0;

    function automatic bit e_idle();
        return !m_run && !m_dv;
    endfunction

    function automatic bit e_start();
        return m_run && !m_ack && !(m_cyc + 1 == TO);
    endfunction

    always @(posedge ap_clk or negedge ap_rst_n) begin
        bit arhs, awhs, rdec, bdec, ner, new_, idle, fin, to;
        int old_rd, old_wr;
        if (!ap_rst_n) begin
            m_rd = 0; m_wr = 0; m_er = 0; m_ew = 0;
            m_run = 0; m_ack = 0; m_cdone = 0; m_dv = 0;
            m_cyc = 0; m_stat = 3'b000; m_dcyc = 0;
        end else begin
            arhs = core_arvalid && m_axi_arready && (m_rd < MAXR);
            awhs = core_awvalid && m_axi_awready && (m_wr < MAXW);
            rdec = m_axi_rvalid && m_axi_rready && m_axi_rlast;
            bdec = m_axi_bvalid && m_axi_bready;
            ner  = m_axi_rvalid && m_axi_rready && (m_axi_rresp != 2'b00);
            new_ = bdec && (m_axi_bresp != 2'b00);
            idle = e_idle();
            old_rd = m_rd;
            old_wr = m_wr;
            if (arhs && !rdec) m_rd++;
            else if (rdec && !arhs && m_rd > 0) m_rd--;
            if (awhs && !bdec) m_wr++;
            else if (bdec && !awhs && m_wr > 0) m_wr--;
            if (idle && cmd_valid) begin
                m_er = ner; m_ew = new_;
            end else begin
                m_er = m_er | ner; m_ew = m_ew | new_;
            end
            fin = 0; to = 0;
            if (idle) begin
                if (cmd_valid) begin
                    m_run = 1; m_ack = 0; m_cdone = 0; m_cyc = 0;
                end
            end else if (m_run) begin
                m_cyc++;
                if (m_cyc == TO) begin
                    fin = 1; to = 1;
                end else if (!m_ack) begin
                    if (core_ap_ready) begin
                        m_ack = 1; m_cdone = core_ap_done;
                    end
                end else if (!m_cdone) begin
                    m_cdone = core_ap_done;
                end else if (old_rd == 0 && old_wr == 0) begin
                    fin = 1;
                end
                if (fin) begin
                    m_run = 0; m_dv = 1;
                    m_stat = {to, m_ew, m_er};
                    m_dcyc = m_cyc;
                end
            end else if (m_dv && done_ready) begin
                m_dv = 0;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge ap_clk) begin
        chk("cmd_ready",     32'(cmd_ready),     32'(e_idle()));
        chk("core_ap_start", 32'(core_ap_start), 32'(e_start()));
        chk("done_valid",    32'(done_valid),    32'(m_dv));
        chk("m_axi_arvalid", 32'(m_axi_arvalid), 32'(core_arvalid && (m_rd < MAXR)));
        chk("core_arready",  32'(core_arready),  32'(m_axi_arready && (m_rd < MAXR)));
        chk("m_axi_awvalid", 32'(m_axi_awvalid), 32'(core_awvalid && (m_wr < MAXW)));
        chk("core_awready",  32'(core_awready),  32'(m_axi_awready && (m_wr < MAXW)));
        if (m_dv) begin
            chk("done_status", 32'(done_status), 32'(m_stat));
            chk("done_cycles", done_cycles,      32'(m_dcyc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge ap_clk);
    endtask

    task automatic clr();
        cmd_valid = 0; core_ap_ready = 0; core_ap_done = 0;
        core_arvalid = 0; m_axi_arready = 0; core_awvalid = 0; m_axi_awready = 0;
        m_axi_rvalid = 0; m_axi_rready = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        m_axi_bvalid = 0; m_axi_bready = 0; m_axi_bresp = 0;
    endtask

    initial begin
        // reset state
        repeat (3) cyc();
        at_neg();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_done_valid", 32'(done_valid), 0);
        chk("rst_ap_start", 32'(core_ap_start), 0);
        chk("rst_status", 32'(done_status), 0);
        chk("rst_cycles", done_cycles, 0);
        cyc();
        ap_rst_n = 1;

        // 1: run with no traffic, ap_ready at t2, ap_done at t10
        cyc(); clr(); done_ready = 1; cmd_valid = 1;
        at_neg(); chk("t1_cmd_ready", 32'(cmd_ready), 1);
        cyc(); cmd_valid = 0;                                  // t1
        at_neg(); chk("t1_ap_start", 32'(core_ap_start), 1);
        chk("t1_busy", 32'(cmd_ready), 0);
        cyc(); core_ap_ready = 1;                              // t2
        cyc(); core_ap_ready = 0;                              // t3
        at_neg(); chk("t1_ap_start_low", 32'(core_ap_start), 0);
        for (int t = 4; t <= 10; t++) begin
            cyc(); core_ap_done = (t == 10);
        end
        cyc(); core_ap_done = 0;                               // t11
        at_neg(); chk("t1_drain_dv", 32'(done_valid), 0);
        cyc();                                                 // t12
        at_neg(); chk("t1_done_valid", 32'(done_valid), 1);
        chk("t1_status", 32'(done_status), 0);
        chk("t1_cycles", done_cycles, 11);
        cyc();                                                 // t13
        at_neg(); chk("t1_dv_drop", 32'(done_valid), 0);
        chk("t1_cmd_ready_back", 32'(cmd_ready), 1);

        // 2: read limit of 2 while idle
        cyc(); clr(); core_arvalid = 1; m_axi_arready = 1;
        at_neg(); chk("t2_ar0", 32'(m_axi_arvalid), 1);
        cyc(); at_neg(); chk("t2_ar1", 32'(m_axi_arvalid), 1);
        cyc(); at_neg(); chk("t2_blocked", 32'(m_axi_arvalid), 0);
        chk("t2_blocked_rdy", 32'(core_arready), 0);
        cyc(); m_axi_rvalid = 1; m_axi_rready = 1; m_axi_rlast = 1;
        at_neg(); chk("t2_still_full", 32'(m_axi_arvalid), 0);
        cyc();                                    // one slot: AR and rlast together
        at_neg(); chk("t2_open", 32'(m_axi_arvalid), 1);
        cyc(); m_axi_rvalid = 0; m_axi_rlast = 0;
        at_neg(); chk("t2_same_cycle_hold", 32'(m_axi_arvalid), 1);
        cyc(); core_arvalid = 0;
        at_neg(); chk("t2_full_again", 32'(core_arready), 0);
        cyc(); m_axi_rvalid = 1; m_axi_rlast = 1;
        cyc();
        cyc(); clr();

        // 3: ap_done with two writes outstanding, one bad bresp
        cyc(); done_ready = 1; cmd_valid = 1;                  // T0
        cyc(); cmd_valid = 0; core_ap_ready = 1;
        core_awvalid = 1; m_axi_awready = 1;                   // T1
        cyc(); core_ap_ready = 0;                              // T2
        cyc(); core_awvalid = 0; core_ap_done = 1;             // T3
        cyc(); core_ap_done = 0;                               // T4
        at_neg(); chk("t3_drain_hold0", 32'(done_valid), 0);
        cyc(); at_neg(); chk("t3_drain_hold1", 32'(done_valid), 0);
        cyc(); m_axi_bvalid = 1; m_axi_bready = 1; m_axi_bresp = 2'b10;  // T6
        cyc(); m_axi_bresp = 2'b00;                            // T7
        cyc(); m_axi_bvalid = 0;                               // T8
        at_neg(); chk("t3_drain_hold2", 32'(done_valid), 0);
        cyc();                                                 // T9
        at_neg(); chk("t3_done_valid", 32'(done_valid), 1);
        chk("t3_status", 32'(done_status), 32'h2);
        chk("t3_cycles", done_cycles, 8);
        cyc(); clr();

        // 4 + 6: timeout with no ap_ready, then report held for 5 cycles
        cyc(); done_ready = 0; cmd_valid = 1;                  // T0
        for (int t = 1; t <= 16; t++) begin
            cyc(); cmd_valid = 0;
            at_neg();
            if (t == 15) chk("t4_start_before", 32'(core_ap_start), 1);
            if (t == 16) chk("t4_start_drop", 32'(core_ap_start), 0);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(); cmd_valid = 1;                              // T17..T21
            at_neg();
            chk("t6_dv_held", 32'(done_valid), 1);
            chk("t6_status_held", 32'(done_status), 32'h4);
            chk("t6_cycles_held", done_cycles, 16);
            chk("t6_cmd_blocked", 32'(cmd_ready), 0);
        end
        cyc(); cmd_valid = 0; done_ready = 1;                  // T22
        at_neg(); chk("t6_dv_last", 32'(done_valid), 1);
        cyc();
        at_neg(); chk("t6_idle", 32'(cmd_ready), 1);

        // 5: reset in RUN with both limits reached
        cyc(); clr(); done_ready = 1; cmd_valid = 1;
        cyc(); cmd_valid = 0; core_ap_ready = 1;
        core_arvalid = 1; m_axi_arready = 1; core_awvalid = 1; m_axi_awready = 1;
        cyc(); core_ap_ready = 0;
        cyc();
        cyc();
        at_neg(); chk("t5_rd_full", 32'(m_axi_arvalid), 0);
        chk("t5_wr_full", 32'(m_axi_awvalid), 0);
        #2 ap_rst_n = 0;
        #1;
        chk("t5_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_rst_dv", 32'(done_valid), 0);
        chk("t5_rst_ar_open", 32'(m_axi_arvalid), 1);
        chk("t5_rst_aw_open", 32'(m_axi_awvalid), 1);
        chk("t5_rst_cycles", done_cycles, 0);
        cyc(); cyc(); ap_rst_n = 1;
        at_neg(); chk("t5_post_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_post_ar_open", 32'(core_arready), 1);
        cyc(); clr();

        // randomized traffic and core behaviour
        for (int i = 0; i < 4000; i++) begin
            cyc();
            cmd_valid     = ($urandom_range(0, 3) == 0);
            done_ready    = ($urandom_range(0, 2) != 0);
            core_ap_ready = ($urandom_range(0, 2) == 0);
            core_ap_done  = ($urandom_range(0, 5) == 0);
            core_arvalid  = ($urandom_range(0, 1) == 0);
            m_axi_arready = ($urandom_range(0, 2) != 0);
            core_awvalid  = ($urandom_range(0, 1) == 0);
            m_axi_awready = ($urandom_range(0, 2) != 0);
            m_axi_rvalid  = ($urandom_range(0, 1) == 0);
            m_axi_rready  = ($urandom_range(0, 3) != 0);
            m_axi_rlast   = ($urandom_range(0, 1) == 0);
            m_axi_rresp   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            m_axi_bvalid  = ($urandom_range(0, 1) == 0);
            m_axi_bready  = ($urandom_range(0, 3) != 0);
            m_axi_bresp   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        cyc(); clr();
        at_neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
